// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: store lane steering, load alignment/extension,
// misalignment detection and a request/ready handshake that stalls the pipeline.
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MEM_memory_read,
    input  logic                MEM_memory_write,
    input  logic [2:0]          MEM_funct3,
    input  logic [XLEN-1:0]     MEM_alu_result,
    input  logic [XLEN-1:0]     MEM_read_data2,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ready,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     mem_load_data,
    output logic                mem_stall,
    output logic                misaligned_exception
);

    // state  | meaning
    // IDLE   | waiting for a load/store; first cycle of an aligned access stalls here
    // ACCESS | request outstanding, held until mem_ready
    // DONE   | response taken, stall released so EX/MEM advances
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic            access;
    logic            is_store;
    logic [1:0]      offset;
    logic            is_word;
    logic            is_half;
    logic            misaligned;
    logic            aligned_access;

    logic [XLEN-1:0] st_wdata;
    logic [NB-1:0]   st_wstrb;

    logic [2:0]      funct3_r;
    logic [1:0]      offset_r;
    logic [4:0]      byte_bit_off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    assign access         = MEM_memory_read | MEM_memory_write;
    assign is_store       = MEM_memory_write;
    assign offset         = MEM_alu_result[1:0];
    assign is_word        = MEM_funct3[1];
    assign is_half        = (MEM_funct3[1:0] == 2'b01);
    assign misaligned     = (is_half & offset[0]) | (is_word & (offset != 2'b00));
    assign aligned_access = access & ~misaligned;

    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        if (is_store) begin
            if (is_word) begin
                st_wdata = MEM_read_data2;
                st_wstrb = '1;
            end else if (is_half) begin
                st_wdata = {(XLEN/16){MEM_read_data2[15:0]}};
                st_wstrb = {{(NB-2){1'b0}}, 2'b11} << offset;
            end else begin
                st_wdata = {(XLEN/8){MEM_read_data2[7:0]}};
                st_wstrb = {{(NB-1){1'b0}}, 1'b1} << offset;
            end
        end
    end

    // Extraction uses the offset/funct3 latched at request time, not the live inputs.
    assign byte_bit_off = {offset_r, 3'b000};
    assign ld_byte      = mem_rdata[byte_bit_off +: 8];
    assign ld_half      = offset_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_ext = mem_rdata;
        if (funct3_r[1:0] == 2'b00) begin
            ld_ext = {{(XLEN-8){~funct3_r[2] & ld_byte[7]}}, ld_byte};
        end else if (funct3_r[1:0] == 2'b01) begin
            ld_ext = {{(XLEN-16){~funct3_r[2] & ld_half[15]}}, ld_half};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (aligned_access) state_next = ACCESS;
            ACCESS:  if (mem_ready)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req              = 1'b0;
        mem_stall            = 1'b0;
        misaligned_exception = 1'b0;
        case (state)
            IDLE: begin
                mem_stall            = aligned_access;
                misaligned_exception = access & misaligned;
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            mem_load_data <= '0;
            funct3_r      <= '0;
            offset_r      <= '0;
        end else begin
            if (state == IDLE && aligned_access) begin
                mem_we    <= is_store;
                mem_addr  <= {MEM_alu_result[XLEN-1:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_wstrb <= st_wstrb;
                funct3_r  <= MEM_funct3;
                offset_r  <= offset;
            end
            if (state == ACCESS && mem_ready && !mem_we) begin
                mem_load_data <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit: handshake timing, steering,
// extraction, misalignment, reset during an access and back-to-back stores.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] alu, rs2;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] mem_load_data;
    logic        mem_stall, misaligned_exception;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk),
        .reset(reset),
        .MEM_memory_read(rd),
        .MEM_memory_write(wr),
        .MEM_funct3(f3),
        .MEM_alu_result(alu),
        .MEM_read_data2(rs2),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_load_data(mem_load_data),
        .mem_stall(mem_stall),
        .misaligned_exception(misaligned_exception)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          waits;
        logic        mis;
        logic        we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic clear_inputs();
        rd = 1'b0; wr = 1'b0; f3 = 3'b000; alu = '0; rs2 = '0;
    endtask

    // Starts and ends just after a rising edge.
    task automatic run_vec(input vec_t v);
        rd = v.rd; wr = v.wr; f3 = v.f3; alu = v.addr; rs2 = v.rs2;
        mem_ready = 1'b0;
        @(negedge clk);
        if (v.mis) begin
            chk({v.name, " exc"},   {31'b0, misaligned_exception}, 32'd1);
            chk({v.name, " stall"}, {31'b0, mem_stall}, 32'd0);
            chk({v.name, " req"},   {31'b0, mem_req}, 32'd0);
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            chk({v.name, " exc clr"}, {31'b0, misaligned_exception}, 32'd0);
            chk({v.name, " req idle"}, {31'b0, mem_req}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        chk({v.name, " idle stall"}, {31'b0, mem_stall}, 32'd1);
        chk({v.name, " idle req"},   {31'b0, mem_req}, 32'd0);
        chk({v.name, " idle exc"},   {31'b0, misaligned_exception}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i <= v.waits; i++) begin
            mem_ready = (i == v.waits);
            mem_rdata = (i == v.waits) ? v.rdata : 32'h0BAD0BAD;
            @(negedge clk);
            chk($sformatf("%s req c%0d", v.name, i),   {31'b0, mem_req}, 32'd1);
            chk($sformatf("%s stall c%0d", v.name, i), {31'b0, mem_stall}, 32'd1);
            chk($sformatf("%s we c%0d", v.name, i),    {31'b0, mem_we}, {31'b0, v.we});
            chk($sformatf("%s addr c%0d", v.name, i),  mem_addr, v.exp_addr);
            chk($sformatf("%s wstrb c%0d", v.name, i), {28'b0, mem_wstrb}, {28'b0, v.exp_wstrb});
            if (v.we)
                chk($sformatf("%s wdata c%0d", v.name, i), mem_wdata, v.exp_wdata);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        chk({v.name, " done req"},   {31'b0, mem_req}, 32'd0);
        chk({v.name, " done stall"}, {31'b0, mem_stall}, 32'd0);
        chk({v.name, " load"},       mem_load_data, v.exp_load);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        //            name     rd    wr    f3      addr          rs2           rdata         w  mis   we    exp_addr      exp_wdata     strb     exp_load
        vecs[0]  = '{"LW",    1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h00000100, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[1]  = '{"LB",    1'b1, 1'b0, 3'b000, 32'h00000203, 32'h0,        32'h80123456, 0, 1'b0, 1'b0, 32'h00000200, 32'h0,        4'b0000, 32'hFFFFFF80};
        vecs[2]  = '{"LBU",   1'b1, 1'b0, 3'b100, 32'h00000203, 32'h0,        32'h80123456, 1, 1'b0, 1'b0, 32'h00000200, 32'h0,        4'b0000, 32'h00000080};
        vecs[3]  = '{"LH",    1'b1, 1'b0, 3'b001, 32'h00000202, 32'h0,        32'h80123456, 0, 1'b0, 1'b0, 32'h00000200, 32'h0,        4'b0000, 32'hFFFF8012};
        vecs[4]  = '{"LHU",   1'b1, 1'b0, 3'b101, 32'h00000202, 32'h0,        32'h80123456, 0, 1'b0, 1'b0, 32'h00000200, 32'h0,        4'b0000, 32'h00008012};
        vecs[5]  = '{"SB",    1'b0, 1'b1, 3'b000, 32'h00000001, 32'h000000AB, 32'h0,        1, 1'b0, 1'b1, 32'h00000000, 32'hABABABAB, 4'b0010, 32'h00008012};
        vecs[6]  = '{"SH",    1'b0, 1'b1, 3'b001, 32'h00000002, 32'h00001234, 32'h0,        0, 1'b0, 1'b1, 32'h00000000, 32'h12341234, 4'b1100, 32'h00008012};
        vecs[7]  = '{"LWmis", 1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[8]  = '{"SHmis", 1'b0, 1'b1, 3'b001, 32'h00000101, 32'h00001234, 32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[9]  = '{"SW0",   1'b0, 1'b1, 3'b010, 32'h00000010, 32'hCAFEF00D, 32'h0,        0, 1'b0, 1'b1, 32'h00000010, 32'hCAFEF00D, 4'b1111, 32'h00008012};
        vecs[10] = '{"SW1",   1'b0, 1'b1, 3'b010, 32'h00000014, 32'h01020304, 32'h0,        0, 1'b0, 1'b1, 32'h00000014, 32'h01020304, 4'b1111, 32'h00008012};
        vecs[11] = '{"RW",    1'b1, 1'b1, 3'b010, 32'h00000020, 32'h55AA55AA, 32'h12345678, 0, 1'b0, 1'b1, 32'h00000020, 32'h55AA55AA, 4'b1111, 32'h00008012};
        vecs[12] = '{"LBpos", 1'b1, 1'b0, 3'b000, 32'h00000301, 32'h0,        32'h00007F00, 0, 1'b0, 1'b0, 32'h00000300, 32'h0,        4'b0000, 32'h0000007F};

        reset = 1'b1;
        clear_inputs();
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst req",   {31'b0, mem_req}, 32'd0);
        chk("rst we",    {31'b0, mem_we}, 32'd0);
        chk("rst addr",  mem_addr, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst load",  mem_load_data, 32'd0);
        chk("rst stall", {31'b0, mem_stall}, 32'd0);
        chk("rst exc",   {31'b0, misaligned_exception}, 32'd0);

        // mem_ready while idle must not load anything
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("idle ready load", mem_load_data, 32'd0);
        chk("idle ready req",  {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // SW0 and SW1 run back to back with no idle cycle in between
        for (int k = 0; k < 13; k++) run_vec(vecs[k]);

        // Reset while a load is outstanding drops the response and clears the result
        rd = 1'b1; f3 = 3'b010; alu = 32'h00000300;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid req before", {31'b0, mem_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid req",   {31'b0, mem_req}, 32'd0);
        chk("rstmid load",  mem_load_data, 32'd0);
        chk("rstmid stall", {31'b0, mem_stall}, 32'd0);
        chk("rstmid addr",  mem_addr, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("late ready load", mem_load_data, 32'd0);
        chk("late ready req",  {31'b0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, directly downstream of the EX/MEM pipeline register.
- Consumes MEM_memory_read/MEM_memory_write/MEM_funct3/MEM_alu_result/MEM_read_data2. Drives a request/ready data-memory port.
- Performs store lane steering, load alignment and extension, and misalignment detection.
- Raises mem_stall, which feeds pipeline_stall, while an access is outstanding.

Parameters:
XLEN, 32, datapath/address width; byte-lane logic sized XLEN/8 (only 32 supported).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
MEM_memory_read  input  1  load in MEM stage
MEM_memory_write  input  1  store in MEM stage
MEM_funct3  input  3  access width/sign (RV32I load/store encoding)
MEM_alu_result  input  XLEN  effective byte address
MEM_read_data2  input  XLEN  store data (rs2)
mem_req  output  1  request valid to data memory
mem_we  output  1  1 = write, 0 = read
mem_addr  output  XLEN  word-aligned address, bits[1:0] = 0
mem_wdata  output  XLEN  lane-steered store data
mem_wstrb  output  XLEN/8  byte write strobes
mem_ready  input  1  memory completes current request this cycle
mem_rdata  input  XLEN  read word, valid when mem_ready
mem_load_data  output  XLEN  aligned, extended load result
mem_stall  output  1  hold pipeline (to pipeline_stall)
misaligned_exception  output  1  misaligned access detected

Behaviour:
- access = MEM_memory_read | MEM_memory_write. If both are set, the access is a store.
- offset = MEM_alu_result[1:0].
- Width from funct3[1:0]: 00 byte, 01 half, 1x word. funct3[2] = 1 selects zero-extension for loads.
- Misaligned: half with offset[0] = 1, or word with offset != 0.
- FSM states IDLE, ACCESS, DONE. Reset value IDLE.
- IDLE:
  - access and aligned: go to ACCESS. Latch mem_we, mem_addr = {addr[XLEN-1:2], 2'b00}, mem_wdata and mem_wstrb, plus funct3/offset for load extraction.
  - access and misaligned: stay IDLE, misaligned_exception = 1 combinationally this cycle, no request, no stall.
  - no access: stay IDLE.
- ACCESS: mem_req = 1, with addr/we/wdata/wstrb held stable. On mem_ready go to DONE. For a load, also register the extended result into mem_load_data.
- DONE: go to IDLE unconditionally. mem_stall = 0, so the EX/MEM register advances on this edge.
- mem_stall = (IDLE & access & aligned) | ACCESS. It is combinational so the EX/MEM register holds on the first cycle.
- mem_req is decoded from state (ACCESS only) and never asserted in IDLE or DONE.
- mem_ready in IDLE or DONE is ignored.
- Minimum occupancy with mem_ready in the first ACCESS cycle: 3 cycles (IDLE stall, ACCESS, DONE). Each extra wait cycle adds 1.
- Store steering:
  - SB: wdata = byte replicated 4x, wstrb = 0001 << offset.
  - SH: wdata = halfword replicated 2x, wstrb = 0011 << offset.
  - SW: wdata = rs2, wstrb = 1111.
- mem_wstrb = 0 for loads.
- Load extraction: byte = rdata[8*offset+7 : 8*offset], half = rdata[8*offset+15 : 8*offset]. Sign- or zero-extend per funct3[2]. Word passes through.
- mem_load_data holds its value except on load completion.
- Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, mem_load_data 0, state IDLE. With no access, mem_stall and misaligned_exception are 0.
- Reset mid-ACCESS: IDLE and mem_req = 0 after the edge. The outstanding response is dropped and mem_load_data is cleared.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE and stalls again. No access is lost or duplicated.

Test Plan:
- LW addr 0x100, mem_ready after 2 wait cycles, rdata 0xDEADBEEF -> mem_req high 3 cycles, addr 0x100, wstrb 0. mem_stall high 4 cycles then low in DONE. mem_load_data = 0xDEADBEEF.
- LB/LBU addr 0x203, rdata 0x80123456 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH/LHU addr 0x202, rdata 0x80123456 -> 0xFFFF8012 / 0x00008012.
- SB addr 0x1, rs2 0x000000AB -> wdata 0xABABABAB, wstrb 0010, mem_we 1. SH addr 0x2, rs2 0x1234 -> wdata 0x12341234, wstrb 1100.
- LW addr 0x102 and SH addr 0x101 -> misaligned_exception 1 for one cycle, mem_req never asserted, mem_stall 0.
- Reset asserted in ACCESS with mem_ready low -> next cycle state IDLE, mem_req 0, mem_load_data 0. A later mem_ready pulse is ignored.
- Two consecutive SW (0x10, 0x14), ready immediate -> exactly two requests in order, 3 cycles each, no extra stall between them.
